// File: rtl/instr_fetch.sv
// Instruction fetch stage: fetch PC, one-cycle-latency imem read, prefetch queue to decode.
// Optional macro IFETCH_BUBBLE_CNT_EN adds the perf_bubbles decode-starvation counter.
module instr_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  output logic        imem_en,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready
`ifdef IFETCH_BUBBLE_CNT_EN
  ,
  output logic [15:0] perf_bubbles
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [15:0]      fetch_pc_q, fetch_pc_d;
  logic [15:0]      inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [15:0]      instr_mem_q [DEPTH];
  logic [15:0]      instr_mem_d [DEPTH];
  logic [15:0]      pc_mem_q [DEPTH];
  logic [15:0]      pc_mem_d [DEPTH];

  logic [CNT_W-1:0] used;
  logic             issue;
  logic             push;
  logic             pop;

  // Decode handshake: ir/ir_pc are meaningful while ir_valid is high; the head entry is
  // consumed on every clock edge where ir_valid && ir_ready. ir_valid never depends on ir_ready.
  always_comb begin
    ir_valid = !reset && (occ_q != '0);
    ir       = ir_valid ? instr_mem_q[head_q] : 16'h0000;
    ir_pc    = ir_valid ? pc_mem_q[head_q]    : 16'h0000;
    imem_en  = issue;
    imem_addr = reset ? 16'h0000 : fetch_pc_q;
  end

  // Credit counts the in-flight read so a returning word always has a free slot.
  always_comb begin
    used          = occ_q + CNT_W'(inflight_q);
    issue         = !reset && !redirect && !halt && (used < DEPTH_C);
    push          = inflight_q && !redirect;
    pop           = ir_valid && ir_ready;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    head_d        = head_q;
    tail_d        = tail_q;
    occ_d         = occ_q;
    instr_mem_d   = instr_mem_q;
    pc_mem_d      = pc_mem_q;

    if (issue) begin
      fetch_pc_d    = fetch_pc_q + 16'd1;
      inflight_pc_d = fetch_pc_q;
    end
    if (push) begin
      instr_mem_d[tail_q] = imem_rdata;
      pc_mem_d[tail_q]    = inflight_pc_q;
      tail_d              = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase

    // Redirect wins over everything: returning data and queued words are stale.
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      occ_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= 16'h0000;
      inflight_q    <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      occ_q         <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      occ_q         <= occ_d;
    end
  end

  // Queue storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

`ifdef IFETCH_BUBBLE_CNT_EN
  logic [15:0] perf_bubbles_q, perf_bubbles_d;

  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    if (!reset && !halt && ir_ready && !ir_valid && (perf_bubbles_q != 16'hFFFF)) begin
      perf_bubbles_d = perf_bubbles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_bubbles_q <= 16'h0000;
    end else begin
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed timing checks plus a randomized run, with a scoreboard
// holding the expected in-order {instr, pc} stream restarted at every reset/redirect.
module tb_instr_fetch;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0010;

  logic        clk;
  logic        reset;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
`ifdef IFETCH_BUBBLE_CNT_EN
  logic [15:0] perf_bubbles;
  logic [15:0] perf0;
`endif

  int checks   = 0;
  int failures = 0;
  int pops;

  logic [31:0] exp_q[$];
  logic [15:0] model_next_pc;

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_en     (imem_en),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready)
`ifdef IFETCH_BUBBLE_CNT_EN
    ,
    .perf_bubbles(perf_bubbles)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- instruction memory model ----------------
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  initial imem_rdata = 16'h0000;
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({mem_word(model_next_pc), model_next_pc});
      model_next_pc = model_next_pc + 16'd1;
    end
  endtask

  task automatic restart_stream(input logic [15:0] pc);
    exp_q.delete();
    model_next_pc = pc;
    refill();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) begin
      check("rst_valid_zero", {15'd0, ir_valid}, 16'h0000);
      restart_stream(RESET_PC);
    end else begin
      if (ir_valid && ir_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_queue_empty", 16'h0001, 16'h0000);
        end else begin
          e = exp_q.pop_front();
          check("sb_ir", ir, e[31:16]);
          check("sb_ir_pc", ir_pc, e[15:0]);
          refill();
        end
      end
      if (redirect) restart_stream(redirect_pc);
      if (halt || redirect) check("no_issue_when_blocked", {15'd0, imem_en}, 16'h0000);
      if (!ir_valid) begin
        check("empty_ir_zero", ir, 16'h0000);
        check("empty_ir_pc_zero", ir_pc, 16'h0000);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      smp();
    end
  endtask

  // Queue is full with ready low: pop one, then the freed credit issues next cycle.
  task automatic pop_one_then_issue(input string tag);
    tick(); ir_ready = 1'b1; smp();
    check({tag, "_full_no_issue"}, {15'd0, imem_en}, 16'h0000);
    tick(); ir_ready = 1'b0; smp();
    check({tag, "_credit_issue"}, {15'd0, imem_en}, 16'h0001);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0; ir_ready = 1'b1;
    model_next_pc = RESET_PC;
    run_cycles(3);
    check("rst_imem_en", {15'd0, imem_en}, 16'h0000);
    check("rst_imem_addr", imem_addr, 16'h0000);
    check("rst_ir", ir, 16'h0000);
    check("rst_ir_pc", ir_pc, 16'h0000);

    // First fetch after reset
    tick(); reset = 1'b0; smp();
    check("first_imem_en", {15'd0, imem_en}, 16'h0001);
    check("first_imem_addr", imem_addr, RESET_PC);
    check("first_valid_c0", {15'd0, ir_valid}, 16'h0000);
    run_cycles(1);
    check("first_valid_c1", {15'd0, ir_valid}, 16'h0000);
    run_cycles(1);
    check("first_valid_c2", {15'd0, ir_valid}, 16'h0001);
    check("first_ir", ir, 16'h1010);
    check("first_ir_pc", ir_pc, 16'h0010);
`ifdef IFETCH_BUBBLE_CNT_EN
    check("perf_first_valid", perf_bubbles, 16'd2);
`endif

    // Steady state: one word per cycle
    for (int i = 0; i < 6; i++) begin
      run_cycles(1);
      check("steady_valid", {15'd0, ir_valid}, 16'h0001);
    end

    // Stall: queue fills to DEPTH and fetch stops
    tick(); ir_ready = 1'b0; smp();
    run_cycles(10);
    check("stall_imem_en", {15'd0, imem_en}, 16'h0000);
    check("stall_valid", {15'd0, ir_valid}, 16'h0001);
    pop_one_then_issue("stall");
    run_cycles(1);
    check("stall_inflight_credit", {15'd0, imem_en}, 16'h0000);
    run_cycles(1);

    // Redirect while a read is in flight
    pop_one_then_issue("redir");
    tick(); redirect = 1'b1; redirect_pc = 16'h0200; smp();
`ifdef IFETCH_BUBBLE_CNT_EN
    perf0 = perf_bubbles;
`endif
    tick(); redirect = 1'b0; ir_ready = 1'b1; smp();
    check("redir_r1_valid", {15'd0, ir_valid}, 16'h0000);
    check("redir_r1_imem_en", {15'd0, imem_en}, 16'h0001);
    check("redir_r1_addr", imem_addr, 16'h0200);
    run_cycles(1);
    check("redir_r2_valid", {15'd0, ir_valid}, 16'h0000);
    run_cycles(1);
    check("redir_r3_valid", {15'd0, ir_valid}, 16'h0001);
    check("redir_r3_ir_pc", ir_pc, 16'h0200);
    check("redir_r3_ir", ir, 16'h1200);
`ifdef IFETCH_BUBBLE_CNT_EN
    check("perf_redirect_delta", perf_bubbles - perf0, 16'd2);
`endif

    // Full queue then halt: exactly DEPTH words drain, no new reads
    tick(); ir_ready = 1'b0; smp();
    run_cycles(8);
    tick(); halt = 1'b1; ir_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      smp();
      check("halt_full_no_issue", {15'd0, imem_en}, 16'h0000);
      if (ir_valid) pops++;
      tick();
    end
    check("halt_full_drain_count", 16'(pops), 16'(DEPTH));
    halt = 1'b0; smp();
    check("halt_release_issue", {15'd0, imem_en}, 16'h0001);

    // Halt mid-stream: queue drains, fetch stays off
    run_cycles(4);
    tick(); halt = 1'b1; smp();
    for (int i = 0; i < 5; i++) begin
      check("halt_mid_no_issue", {15'd0, imem_en}, 16'h0000);
      run_cycles(1);
    end
    check("halt_mid_drained", {15'd0, ir_valid}, 16'h0000);
    tick(); halt = 1'b0; smp();
    run_cycles(4);

    // Redirect to the top of the address space
    tick(); redirect = 1'b1; redirect_pc = 16'hFFFF; smp();
    tick(); redirect = 1'b0; smp();
    run_cycles(2);
    check("wrap_ir_pc_ffff", ir_pc, 16'hFFFF);
    check("wrap_ir_ffff", ir, 16'h0FFF);
    run_cycles(1);
    check("wrap_ir_pc_0000", ir_pc, 16'h0000);
    check("wrap_ir_0000", ir, 16'h1000);

    // Reset while a read is in flight
    tick(); reset = 1'b1; smp();
    tick(); reset = 1'b0; smp();
    check("rerst_imem_en", {15'd0, imem_en}, 16'h0001);
    check("rerst_addr", imem_addr, RESET_PC);
    check("rerst_valid", {15'd0, ir_valid}, 16'h0000);
    run_cycles(2);
    check("rerst_ir_pc", ir_pc, RESET_PC);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      tick();
      reset       = ($urandom_range(0, 199) == 0);
      redirect    = !reset && ($urandom_range(0, 29) == 0);
      redirect_pc = 16'($urandom);
      if ($urandom_range(0, 14) == 0) halt = !halt;
      ir_ready    = ($urandom_range(0, 9) < 7);
      smp();
    end

    tick(); reset = 1'b0; redirect = 1'b0; halt = 1'b0; ir_ready = 1'b1; smp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
